cfg_chain_loader: RTL and testbench
===================================

Name: cfg_chain_loader

Overview:
Drives the serial configuration chain formed by daisy-chained interconnect/LE config shift registers. Each register shifts `{cfg[N-2:0], config_data_in}` on every clk edge where config_en=1.
- Accepts configuration words over a valid/ready stream and serializes them MSB-first onto the chain head.
- Captures the bits emerging from the chain tail into readback words, so the previous chain contents can be verified non-destructively on the next load.
- Sits between the bitstream source (host/SPI bridge) and the fabric tile chain.

Parameters:
- WORD_W, 8, width of input/readback words.
- CHAIN_LEN, 48, total config bits in the chain (LE_INPUTS=4 interconnect: 4*4*3); any value >=1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived, not overridden).

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load; sampled in IDLE only.
- abort  in  1  synchronous abort; highest priority after reset.
- word_in  in  WORD_W  next config word; bit WORD_W-1 is shifted first.
- word_valid  in  1  word_in valid.
- word_ready  out  1  loader accepts word this cycle.
- config_en  out  1  chain shift enable.
- config_data_out  out  1  serial bit to chain head (chain's config_data_in).
- config_data_in  in  1  serial bit from chain tail (last element's config_data_out).
- rb_word  out  WORD_W  readback word, first-captured bit at MSB.
- rb_valid  out  1  one-cycle pulse; rb_word valid.
- busy  out  1  high in LOAD or SHIFT.
- done  out  1  one-cycle pulse at completion of a full CHAIN_LEN load.

Behaviour:
- Reset: state=IDLE, bit_cnt=0, word/readback shift regs=0. All outputs 0 (word_ready, config_en, config_data_out, rb_word, rb_valid, busy, done).
- All outputs are decoded from registers only; no combinational input-to-output path.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 -> LOAD, bit_cnt<=0.
  - start in any other state is ignored.
- LOAD:
  - word_ready=1, config_en=0.
  - On word_valid&word_ready: sreg<=word_in; nbits<=min(WORD_W, CHAIN_LEN-bit_cnt); wcnt<=0; -> SHIFT.
  - word_valid=0 stalls indefinitely; chain is untouched.
- SHIFT:
  - config_en=1 and config_data_out=sreg[WORD_W-1] every cycle.
  - Each edge: sreg<<=1; rbreg<={rbreg[WORD_W-2:0], config_data_in}; wcnt++; bit_cnt++.
  - After nbits cycles:
    - rb_valid=1 for one cycle the next cycle. rb_word = captured bits left-justified; unused low bits are 0 for a partial final word.
    - If bit_cnt==CHAIN_LEN -> DONE, else -> LOAD.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Timing:
  - Chain bits are consumed in the same cycle config_en is high.
  - Minimum cost per word is 1 LOAD cycle + nbits SHIFT cycles.
  - Full load = CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles from accept of first word to done.
- Bit order:
  - First bit shifted ends at chain MSB (CHAIN_LEN-1).
  - Last bit shifted ends at chain bit 0.
  - Readback of the old contents emerges MSB-first.
- Partial final word: only its top (CHAIN_LEN mod WORD_W) bits are shifted; the rest are discarded.
- Abort (any state): -> IDLE next edge.
  - config_en=0 from that cycle.
  - No done, no rb_valid.
  - Chain is left partially shifted; bit_cnt is cleared.
- Simultaneous events:
  - abort and start in IDLE -> stays IDLE.
  - abort and word_valid in LOAD -> word is not accepted (word_ready forced 0 when abort=1 is not allowed, since it would be a comb path; instead the accepted word is dropped).
- nrst mid-operation: immediate return to the reset values above, including config_en=0.

Test Plan:
1. WORD_W=8, CHAIN_LEN=48, after reset. Send start, then words A5,3C,FF,00,81,7E with valid always high. Required:
   - Exactly 48 config_en cycles.
   - Chain model holds 0xA53CFF00817E.
   - done pulses once, 55 cycles after first accept.
   - Six rb_valid pulses, all rb_word=00.
2. Repeat the load with words 11,22,33,44,55,66. Required: rb_word sequence A5,3C,FF,00,81,7E; chain holds 0x112233445566.
3. Backpressure: hold word_valid=0 for 10 cycles between words 2 and 3. Required: word_ready=1 and config_en=0 throughout the stall; final chain contents are identical to scenario 1.
4. CHAIN_LEN=12, words F0,A5. Required:
   - 12 shift cycles.
   - Chain holds 0xF0A.
   - Second rb_word has low 4 bits 0.
   - done pulses once.
5. Assert abort after 20 shift cycles. Required:
   - config_en=0 from the next cycle.
   - busy=0, no done.
   - A following start plus 6 words completes normally.
6. Pull nrst low mid-SHIFT. Required: all outputs 0 asynchronously; the next start works as in scenario 1.

Source files
------------

// File: rtl/cfg_chain_loader.sv
// Serializes configuration words MSB-first onto the fabric config chain head and
// captures the bits displaced from the chain tail as left-justified readback words.
module cfg_chain_loader #(
   parameter  int WORD_W    = 8,
   parameter  int CHAIN_LEN = 48,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              config_en,
   output logic              config_data_out,
   input  logic              config_data_in,
   output logic [WORD_W-1:0] rb_word,
   output logic              rb_valid,
   output logic              busy,
   output logic              done
);

   localparam int NB_W = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            state_q,    state_d;
   logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
   logic [WORD_W-1:0] sreg_q,     sreg_d;
   logic [WORD_W-1:0] rbreg_q,    rbreg_d;
   logic [NB_W-1:0]   wcnt_q,     wcnt_d;
   logic [NB_W-1:0]   nbits_q,    nbits_d;
   logic [WORD_W-1:0] rb_word_q,  rb_word_d;
   logic              rb_valid_q, rb_valid_d;

   logic [WORD_W-1:0] rb_shift;
   int                remaining;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sreg_d     = sreg_q;
      rbreg_d    = rbreg_q;
      wcnt_d     = wcnt_q;
      nbits_d    = nbits_q;
      rb_word_d  = rb_word_q;
      rb_valid_d = 1'b0;
      rb_shift   = {rbreg_q[WORD_W-2:0], config_data_in};
      remaining  = CHAIN_LEN - int'(bit_cnt_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_LOAD;
               bit_cnt_d = '0;
            end
         end
         S_LOAD: begin
            // word_ready is high throughout LOAD, so valid alone completes the handshake
            if (word_valid) begin
               sreg_d  = word_in;
               nbits_d = (remaining < WORD_W) ? NB_W'(remaining) : NB_W'(WORD_W);
               wcnt_d  = '0;
               rbreg_d = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sreg_d    = sreg_q << 1;
            rbreg_d   = rb_shift;
            wcnt_d    = wcnt_q + 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (wcnt_q == nbits_q - 1'b1) begin
               rb_valid_d = 1'b1;
               // a partial final word is left-justified with zero fill below
               rb_word_d  = rb_shift << (WORD_W - int'(nbits_q));
               state_d    = (int'(bit_cnt_q) + 1 == CHAIN_LEN) ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // abort drops any word accepted this cycle and suppresses the readback pulse
      if (abort) begin
         state_d    = S_IDLE;
         bit_cnt_d  = '0;
         rb_valid_d = 1'b0;
         rb_word_d  = rb_word_q;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         sreg_q     <= '0;
         rbreg_q    <= '0;
         wcnt_q     <= '0;
         nbits_q    <= '0;
         rb_word_q  <= '0;
         rb_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sreg_q     <= sreg_d;
         rbreg_q    <= rbreg_d;
         wcnt_q     <= wcnt_d;
         nbits_q    <= nbits_d;
         rb_word_q  <= rb_word_d;
         rb_valid_q <= rb_valid_d;
      end
   end

   assign word_ready      = (state_q == S_LOAD);
   assign config_en       = (state_q == S_SHIFT);
   assign config_data_out = config_en & sreg_q[WORD_W-1];
   assign busy            = (state_q == S_LOAD) || (state_q == S_SHIFT);
   assign done            = (state_q == S_DONE);
   assign rb_word         = rb_word_q;
   assign rb_valid        = rb_valid_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: two instances (48-bit and 12-bit chains) each driving a
// behavioural chain model; readback words are scoreboarded against the model's prior contents.
module tb_cfg_chain_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       nrst       = 1'b1;
   logic       abort      = 1'b0;
   logic [7:0] word_in    = 8'h00;
   logic       word_valid = 1'b0;
   logic       start48    = 1'b0;
   logic       start12    = 1'b0;

   logic       rdy48, en48, cdo48, cdi48, rbv48, busy48, done48;
   logic [7:0] rbw48;
   logic       rdy12, en12, cdo12, cdi12, rbv12, busy12, done12;
   logic [7:0] rbw12;

   logic [47:0] chain48 = '0;
   logic [11:0] chain12 = '0;

   cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(48)) dut (
      .clk(clk), .nrst(nrst), .start(start48), .abort(abort),
      .word_in(word_in), .word_valid(word_valid), .word_ready(rdy48),
      .config_en(en48), .config_data_out(cdo48), .config_data_in(cdi48),
      .rb_word(rbw48), .rb_valid(rbv48), .busy(busy48), .done(done48)
   );

   cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) dut12 (
      .clk(clk), .nrst(nrst), .start(start12), .abort(abort),
      .word_in(word_in), .word_valid(word_valid), .word_ready(rdy12),
      .config_en(en12), .config_data_out(cdo12), .config_data_in(cdi12),
      .rb_word(rbw12), .rb_valid(rbv12), .busy(busy12), .done(done12)
   );

   // Chain models: each element shifts {cfg[N-2:0], data_in} while enabled; no reset.
   always @(posedge clk) if (en48) chain48 <= {chain48[46:0], cdo48};
   always @(posedge clk) if (en12) chain12 <= {chain12[10:0], cdo12};
   assign cdi48 = chain48[47];
   assign cdi12 = chain12[11];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int first_acc = -1;
   int done_cyc = -1;
   int en48_cnt, done48_cnt, rb48_cnt;
   int en12_cnt, done12_cnt, rb12_cnt;
   bit use12 = 1'b0;
   bit last_acc = 1'b0;
   logic [7:0] rbq48[$];
   logic [7:0] rbq12[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_meas();
      en48_cnt = 0; done48_cnt = 0; rb48_cnt = 0;
      en12_cnt = 0; done12_cnt = 0; rb12_cnt = 0;
      first_acc = -1; done_cyc = -1;
   endtask

   // One clock: note handshake before the edge, then sample outputs 1 time unit after it.
   task automatic tick();
      bit acc;
      acc = word_valid && !abort && (use12 ? rdy12 : rdy48);
      @(posedge clk);
      #1;
      cyc++;
      last_acc = acc;
      if (acc && first_acc < 0) first_acc = cyc;
      if (en48) en48_cnt++;
      if (en12) en12_cnt++;
      if (done48) begin done48_cnt++; done_cyc = cyc; end
      if (done12) begin done12_cnt++; done_cyc = cyc; end
      if (rbv48) begin
         rb48_cnt++;
         if (rbq48.size() == 0) begin
            checks++; errors++;
            $error("FAIL rb48_unexpected: rb_valid pulse with rb_word %0h, none expected", rbw48);
         end else check("rb48_word", rbw48, rbq48.pop_front());
      end
      if (rbv12) begin
         rb12_cnt++;
         if (rbq12.size() == 0) begin
            checks++; errors++;
            $error("FAIL rb12_unexpected: rb_valid pulse with rb_word %0h, none expected", rbw12);
         end else check("rb12_word", rbw12, rbq12.pop_front());
      end
   endtask

   task automatic send_word(input logic [7:0] w);
      int n;
      n = 0;
      word_in = w;
      word_valid = 1'b1;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 100);
      check("word_accepted", last_acc, 1);
   endtask

   task automatic wait_done(input bit is12);
      int n;
      n = 0;
      while (((is12 ? done12_cnt : done48_cnt) == 0) && n < 200) begin
         tick();
         n++;
      end
      check("done_seen", (is12 ? done12_cnt : done48_cnt) > 0, 1);
      repeat (3) tick();
   endtask

   task automatic load48(input logic [47:0] data);
      for (int k = 0; k < 6; k++) rbq48.push_back(chain48[47-8*k -: 8]);
      use12 = 1'b0;
      clear_meas();
      start48 = 1'b1;
      tick();
      start48 = 1'b0;
      for (int k = 0; k < 6; k++) send_word(data[47-8*k -: 8]);
      word_valid = 1'b0;
      wait_done(1'b0);
      check("load48_cfg_en_cycles", en48_cnt, 48);
      check("load48_chain", chain48, data);
      check("load48_done_pulses", done48_cnt, 1);
      check("load48_latency", done_cyc - first_acc + 2, 55);
      check("load48_rb_pulses", rb48_cnt, 6);
      check("load48_rb_pending", rbq48.size(), 0);
   endtask

   task automatic load12(input logic [7:0] w0, input logic [7:0] w1);
      rbq12.push_back(chain12[11:4]);
      rbq12.push_back({chain12[3:0], 4'b0000});
      use12 = 1'b1;
      clear_meas();
      start12 = 1'b1;
      tick();
      start12 = 1'b0;
      send_word(w0);
      send_word(w1);
      word_valid = 1'b0;
      wait_done(1'b1);
      check("load12_cfg_en_cycles", en12_cnt, 12);
      check("load12_chain", chain12, {w0, w1[7:4]});
      check("load12_done_pulses", done12_cnt, 1);
      check("load12_rb_pulses", rb12_cnt, 2);
      check("load12_rb_pending", rbq12.size(), 0);
      use12 = 1'b0;
   endtask

   initial begin
      int n;
      int stall_bad;

      // reset state
      #1 nrst = 1'b0;
      repeat (2) tick();
      check("rst_outputs48", {rdy48, en48, cdo48, rbw48, rbv48, busy48, done48}, '0);
      check("rst_outputs12", {rdy12, en12, cdo12, rbw12, rbv12, busy12, done12}, '0);
      nrst = 1'b1;
      tick();
      check("idle_after_rst", {rdy48, en48, busy48, done48}, '0);

      // 1: full load over a zeroed chain, then 2: reload reading back the first image
      load48(48'hA53CFF00817E);
      load48(48'h112233445566);

      // 3: backpressure stall while in LOAD between words 2 and 3
      for (int k = 0; k < 6; k++) rbq48.push_back(chain48[47-8*k -: 8]);
      clear_meas();
      start48 = 1'b1;
      tick();
      start48 = 1'b0;
      send_word(8'hA5);
      send_word(8'h3C);
      word_valid = 1'b0;
      n = 0;
      while (!rdy48 && n < 20) begin tick(); n++; end
      check("stall_reached_load", rdy48, 1);
      stall_bad = 0;
      repeat (10) begin
         tick();
         if (!(rdy48 === 1'b1 && en48 === 1'b0)) stall_bad++;
      end
      check("stall_ready_hold_no_shift", stall_bad, 0);
      check("stall_en_count", en48_cnt, 16);
      send_word(8'hFF);
      send_word(8'h00);
      send_word(8'h81);
      send_word(8'h7E);
      word_valid = 1'b0;
      wait_done(1'b0);
      check("stall_chain", chain48, 48'hA53CFF00817E);
      check("stall_done_pulses", done48_cnt, 1);
      check("stall_rb_pending", rbq48.size(), 0);

      // 4: short chain with partial final word; second load reads back the discarded-tail image
      load12(8'hF0, 8'hA5);
      load12(8'h00, 8'h00);

      // 5: abort after 20 shift cycles
      rbq48.push_back(chain48[47:40]);
      rbq48.push_back(chain48[39:32]);
      clear_meas();
      start48 = 1'b1;
      tick();
      start48 = 1'b0;
      send_word(8'hA5);
      send_word(8'h3C);
      send_word(8'hFF);
      word_valid = 1'b0;
      n = 0;
      while (en48_cnt < 20 && n < 50) begin tick(); n++; end
      check("abort_reached_20", en48_cnt, 20);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_cfg_en", en48, 0);
      check("abort_busy", busy48, 0);
      check("abort_ready", rdy48, 0);
      repeat (12) tick();
      check("abort_no_more_shift", en48_cnt, 20);
      check("abort_no_done", done48_cnt, 0);
      check("abort_rb_pulses", rb48_cnt, 2);
      check("abort_rb_pending", rbq48.size(), 0);
      check("abort_chain_partial", chain48, 48'hF00817EA53CF);

      // abort together with start in IDLE
      abort = 1'b1;
      start48 = 1'b1;
      tick();
      abort = 1'b0;
      start48 = 1'b0;
      check("abort_start_idle", {busy48, rdy48}, 2'b00);

      // abort together with a valid word in LOAD: word dropped, chain untouched
      clear_meas();
      start48 = 1'b1;
      tick();
      start48 = 1'b0;
      check("abort_load_ready", rdy48, 1);
      word_in = 8'h55;
      word_valid = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      word_valid = 1'b0;
      check("abort_load_idle", {busy48, en48, rdy48}, 3'b000);
      repeat (5) tick();
      check("abort_load_no_shift", en48_cnt, 0);
      check("abort_load_chain", chain48, 48'hF00817EA53CF);

      load48(48'h112233445566);

      // 6: asynchronous reset in the middle of SHIFT
      rbq48.push_back(chain48[47:40]);
      clear_meas();
      start48 = 1'b1;
      tick();
      start48 = 1'b0;
      send_word(8'hA5);
      send_word(8'h3C);
      word_valid = 1'b0;
      repeat (3) tick();
      check("pre_rst_shifting", en48, 1);
      #2 nrst = 1'b0;
      #1;
      check("async_rst_outputs", {rdy48, en48, cdo48, rbw48, rbv48, busy48, done48}, '0);
      check("async_rst_rb_pulses", rb48_cnt, 1);
      check("async_rst_rb_pending", rbq48.size(), 0);
      repeat (2) tick();
      check("rst_hold_outputs", {rdy48, en48, busy48, done48}, '0);
      nrst = 1'b1;
      tick();
      load48(48'hA53CFF00817E);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
